pio_key_event_ctrl: RTL and testbench

Avalon-MM master controller that owns the key PIO slave (2-bit edge-capturing input port with IRQ mask at offset 2 and edge-capture at offset 3). After reset it programs the IRQ mask. On each PIO interrupt it reads and clears the edge-capture register, applies a per-key lockout (debounce) window, and queues key-press events into a small FIFO for the consumer logic. This takes key servicing off the soft processor.

---
 rtl/pio_key_event_ctrl.sv | 157 +++++++++++++++
 tb/tb_pio_key_event_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_key_event_ctrl.sv
// rtl/pio_key_event_ctrl.sv - Avalon-MM master servicing a key PIO into a debounced event FIFO
module pio_key_event_ctrl #(
    parameter int NUM_KEYS = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH = 4,
    parameter logic [NUM_KEYS-1:0] IRQ_MASK_INIT = '1,
    localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    output logic [KEY_W-1:0] evt_key,
    input  logic             evt_ready,
    output logic [7:0]       drop_count,
    output logic             busy
);
    localparam int LOCK_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(DEBOUNCE_CYCLES);
    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);
    localparam logic [PTR_W:0] FIFO_FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_ADDR,
        RD_CAP,
        CLEAR,
        EMIT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                init_armed;
    logic [KEY_W-1:0]    key_idx;
    logic [NUM_KEYS-1:0] cap_reg;
    logic [LOCK_W-1:0]   lockout [NUM_KEYS];
    logic [KEY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      fifo_count;
    logic                emit_hit;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                drop;
    logic                unused_readdata;

    assign unused_readdata = ^avm_readdata[31:NUM_KEYS];

    // A press is considered only for a captured key whose lockout has expired.
    assign emit_hit  = (state == EMIT) && cap_reg[key_idx] && (lockout[key_idx] == '0);
    assign fifo_full = (fifo_count == FIFO_FULL_COUNT);
    assign evt_valid = (fifo_count != '0);
    assign evt_key   = fifo_mem[rd_ptr];
    assign pop       = evt_valid && evt_ready;
    assign push      = emit_hit && (!fifo_full || pop);
    assign drop      = emit_hit && fifo_full && !pop;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next     = state;
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = '0;
        case (state)
            INIT: begin
                // Bus stays quiet while reset is held; the mask write is the first clock after release.
                if (init_armed) begin
                    avm_address    = ADDR_IRQ_MASK;
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_writedata  = 32'(IRQ_MASK_INIT);
                    state_next     = IDLE;
                end
            end
            IDLE: begin
                if (pio_irq) state_next = RD_ADDR;
            end
            RD_ADDR: begin
                avm_address    = ADDR_EDGE_CAP;
                avm_chipselect = 1'b1;
                state_next     = RD_CAP;
            end
            RD_CAP: begin
                avm_address = ADDR_EDGE_CAP;
                state_next  = CLEAR;
            end
            CLEAR: begin
                avm_address    = ADDR_EDGE_CAP;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = 32'(cap_reg);
                state_next     = EMIT;
            end
            EMIT: begin
                if (key_idx == LAST_KEY) state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            init_armed <= 1'b0;
            key_idx    <= '0;
            cap_reg    <= '0;
        end else begin
            state      <= state_next;
            init_armed <= 1'b1;
            if (state == EMIT && key_idx != LAST_KEY) key_idx <= key_idx + 1'b1;
            else key_idx <= '0;
            if (state == RD_CAP) cap_reg <= avm_readdata[NUM_KEYS-1:0];
        end
    end

    // Both accepted and dropped presses restart the key's lockout window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_KEYS; k++) lockout[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (emit_hit && key_idx == KEY_W'(k)) lockout[k] <= LOCK_LOAD;
                else if (lockout[k] != '0) lockout[k] <= lockout[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= key_idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pio_key_event_ctrl.sv
// tb/tb_pio_key_event_ctrl.sv - randomized scoreboard bench for pio_key_event_ctrl with a PIO model
module tb_pio_key_event_ctrl;
    localparam int N = 2;
    localparam int D = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        pio_irq = 1'b0;
    logic        evt_valid;
    logic [0:0]  evt_key;
    logic        evt_ready = 1'b0;
    logic [7:0]  drop_count;
    logic        busy;

    always #5 clk = ~clk;

    pio_key_event_ctrl #(
        .NUM_KEYS(N),
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH(DEPTH),
        .IRQ_MASK_INIT(2'b11)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .pio_irq(pio_irq),
        .evt_valid(evt_valid),
        .evt_key(evt_key),
        .evt_ready(evt_ready),
        .drop_count(drop_count),
        .busy(busy)
    );

    typedef struct {
        int e;
        int k;
    } ev_t;

    int tests = 0;
    int fails = 0;

    int          edge_n;
    logic [1:0]  cap, mask, inject, mk_cap;
    int          svc_free, clear_edge, cur_e0, cur_v, exp_drops;
    int          last_acc [N];
    bit          has_acc [N];
    int          exp_q [$];
    ev_t         sched [$];
    logic [1:0]  s_addr;
    logic        s_cs, s_wn;
    logic [31:0] s_wd;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event did not occur (edge %0d)", name, edge_n);
    endtask

    // Scoreboard monitor: checks the head whenever the DUT hands over an event.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("evt_valid", int'(evt_valid), int'(exp_q.size() != 0));
                if (evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) fail_now("evt_unexpected_pop");
                    else begin
                        check("evt_key", int'(evt_key), exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        sched.delete();
        edge_n = 0;
        cap = '0; mask = '0; mk_cap = '0; inject = '0;
        avm_readdata = '0; pio_irq = 1'b0; evt_ready = 1'b0;
        svc_free = 3; clear_edge = -1; cur_e0 = -100; cur_v = 0; exp_drops = 0;
        for (int k = 0; k < N; k++) begin
            has_acc[k] = 1'b0;
            last_acc[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock: sample/check mid-cycle, then apply PIO and reference model at the edge.
    task automatic step();
        logic env_clr, was_irq;
        ev_t  ev;
        @(negedge clk);
        s_addr = avm_address; s_cs = avm_chipselect; s_wn = avm_write_n; s_wd = avm_writedata;
        if (edge_n == 0) begin
            check("rst_address", int'(avm_address), 0);
            check("rst_chipselect", int'(avm_chipselect), 0);
            check("rst_write_n", int'(avm_write_n), 1);
            check("rst_writedata", int'(avm_writedata), 0);
            check("rst_evt_key", int'(evt_key), 0);
            check("rst_busy", int'(busy), 1);
        end else if (edge_n == 1) begin
            check("init_address", int'(avm_address), 2);
            check("init_chipselect", int'(avm_chipselect), 1);
            check("init_write_n", int'(avm_write_n), 0);
            check("init_writedata", int'(avm_writedata), 3);
            check("init_busy", int'(busy), 1);
        end else begin
            check("busy", int'(busy),
                  int'(cur_e0 >= 0 && edge_n >= cur_e0 && edge_n < cur_e0 + 3 + N));
            if (edge_n == cur_e0) begin
                check("rd_address", int'(avm_address), 3);
                check("rd_write_n", int'(avm_write_n), 1);
            end
            if (edge_n == cur_e0 + 2) begin
                check("clr_address", int'(avm_address), 3);
                check("clr_chipselect", int'(avm_chipselect), 1);
                check("clr_write_n", int'(avm_write_n), 0);
                check("clr_writedata", int'(avm_writedata), cur_v);
            end
        end
        check("drop_count", int'(drop_count), exp_drops);

        @(posedge clk);
        #1;
        edge_n++;
        avm_readdata = (s_addr == 2'd3) ? 32'(cap) : (s_addr == 2'd2) ? 32'(mask) : 32'd0;
        if (s_cs && !s_wn && s_addr == 2'd2) mask = s_wd[1:0];
        env_clr = s_cs && !s_wn && s_addr == 2'd3;
        cap = (env_clr ? 2'b00 : cap) | inject;
        pio_irq = |(cap & mask);

        was_irq = |mk_cap;
        mk_cap = ((edge_n == clear_edge) ? 2'b00 : mk_cap) | inject;
        inject = '0;
        if (was_irq && edge_n >= svc_free) begin
            cur_e0 = edge_n;
            cur_v = int'(mk_cap);
            clear_edge = edge_n + 3;
            svc_free = edge_n + 4 + N;
            for (int k = 0; k < N; k++)
                if (mk_cap[k]) sched.push_back('{e: edge_n + 4 + k, k: k});
        end
        while (sched.size() > 0 && sched[0].e == edge_n) begin
            ev = sched.pop_front();
            if (!has_acc[ev.k] || (edge_n - 1 - last_acc[ev.k]) >= D) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(ev.k);
                else if (exp_drops < 255) exp_drops++;
                has_acc[ev.k] = 1'b1;
                last_acc[ev.k] = edge_n;
            end
        end
    endtask

    task automatic random_traffic(input int cycles, input int ready_pct);
        repeat (cycles) begin
            evt_ready = ($urandom_range(0, 99) < ready_pct);
            if (edge_n >= 3 && $urandom_range(0, 5) == 0) inject = 2'($urandom_range(1, 3));
            step();
        end
    endtask

    task automatic wait_service(input string name);
        int prev;
        prev = cur_e0;
        for (int i = 0; i < 40 && cur_e0 == prev; i++) step();
        if (cur_e0 == prev) fail_now(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        random_traffic(800, 70);

        repeat (2500) begin
            evt_ready = 1'b0;
            if (edge_n >= 3 && $urandom_range(0, 2) == 0) inject = 2'b11;
            step();
        end
        check("drop_saturated", int'(drop_count), 255);

        evt_ready = 1'b1;
        repeat (30) step();
        evt_ready = 1'b0;
        repeat (10) step();
        inject = 2'b11;
        wait_service("first_service_timeout");
        repeat (16) step();
        check("two_queued_valid", int'(evt_valid), 1);
        inject = 2'b11;
        wait_service("second_service_timeout");
        while (edge_n < cur_e0 + 2) step();
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_evt_valid", int'(evt_valid), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_chipselect", int'(avm_chipselect), 0);
        check("midrst_address", int'(avm_address), 0);
        check("midrst_drop_count", int'(drop_count), 0);
        do_reset();

        random_traffic(400, 60);
        evt_ready = 1'b1;
        repeat (30) step();
        check("drained", int'(evt_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
